store_fwd_buffer: RTL
=====================

Name: store_fwd_buffer

Overview:
- Parametrised store buffer between the MEM stage and the data SRAM port.
- Queues committed stores, drains them in order to memory through a req/ack handshake, and forwards buffered store data to younger loads with per-byte merging.
- Successor to the single-entry MEM/WB store-to-load forward check: multi-entry, byte-granular, and it holds state across cycles.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width; multiple of 8. NB = DATA_W/8 byte lanes; OFF = log2(NB) offset bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  MEM stage presents a store
- st_addr  in  ADDR_W  store byte address; the low OFF bits are ignored
- st_wdata  in  DATA_W  store data, lane-aligned
- st_wstrb  in  NB  store byte enables
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  ADDR_W  load address probed for forwarding
- ld_fwd_data  out  DATA_W  merged forwarded bytes; lanes not in ld_fwd_mask are 0
- ld_fwd_mask  out  NB  lanes supplied by the buffer
- ld_fwd_full  out  1  ld_fwd_mask is all ones
- mem_req  out  1  head entry is presented to memory
- mem_addr  out  ADDR_W  head address with the low OFF bits forced to 0
- mem_wdata  out  DATA_W  head data
- mem_wstrb  out  NB  head byte enables
- mem_ack  in  1  memory accepts the head store this cycle
- empty  out  1  no valid entries

Behaviour:
- Storage: circular array of DEPTH entries, each holding {valid, addr[ADDR_W-1:OFF], data, strb}. Uses head and tail pointers of width log2(DEPTH) plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset: all valid bits 0, head = tail = 0, count = 0. After reset, mem_req=0, st_ready=1, empty=1, ld_fwd_mask=0, ld_fwd_data=0, ld_fwd_full=0. A reset arriving mid-drain discards every queued store, including one presented with mem_req; no ack is awaited.
- Push: on st_valid & st_ready, the entry at tail is written, tail advances and the entry becomes valid at the next edge. A store with st_wstrb=0 is still queued.
- st_ready = (count != DEPTH). It depends only on registered state and is never combinational from mem_ack. When full, a same-cycle ack does not admit a push.
- Drain: mem_req = !empty. mem_addr, mem_wdata and mem_wstrb show the head entry and stay stable while mem_req=1 and mem_ack=0. On mem_req & mem_ack the head is invalidated and head advances. mem_ack while mem_req=0 is ignored.
- A store is first offered on mem_req in the cycle after its push. The earliest pop is that same cycle if mem_ack=1.
- Simultaneous push and pop: count is unchanged and both pointers advance, including at the wrap from DEPTH-1 to 0.
- Forwarding:
  - Combinational. Considers only valid entries already in the buffer, not the st_* inputs of the same cycle.
  - An entry matches when its addr equals ld_addr[ADDR_W-1:OFF].
  - For each lane, the youngest matching entry whose strb bit is set supplies the byte, with age measured from tail backwards.
  - ld_fwd_mask is the OR of the strb bits of all matching entries.
  - An entry being popped this cycle still forwards this cycle.
- Program order: the buffer preserves store order. It never coalesces entries and never reorders them.

Test Plan:
- Reset, then one store: push addr 0x100, data 0xAABBCCDD, strb 1111; hold mem_ack=0 for 3 cycles, then 1. -> mem_req rises the cycle after the push; mem_addr/mem_wdata stay 0x100/0xAABBCCDD for all 4 cycles; empty=1 the cycle after the ack.
- Fill to full: push 4 stores with mem_ack=0. -> st_ready=0 after the 4th push; a 5th st_valid is not accepted. Assert mem_ack for one cycle with st_valid held. -> st_ready returns to 1 only the cycle after the pop.
- Byte merge: push 0x200 data 0x11223344 strb 1111, then 0x200 data 0x000000EE strb 0001, then 0x203 data 0x99000000 strb 1000; probe ld_addr=0x200. -> ld_fwd_data=0x992233EE, ld_fwd_mask=1111, ld_fwd_full=1.
- Partial hit: buffer holds 0x300 strb 0011 data 0x0000BEEF; probe ld_addr 0x300 -> mask 0011, data 0x0000BEEF, full=0. Probe 0x304 -> mask 0000, data 0.
- Wrap and simultaneous push/pop: stream 10 stores with mem_ack=1 every cycle. -> count stays at most 1; memory receives the 10 stores in push order with correct addr/data across the pointer wrap.
- Reset mid-drain: 3 stores queued, mem_req=1, assert rst for one cycle. -> mem_req=0, empty=1, ld_fwd_mask=0 the next cycle; no queued store is later emitted.

Source files
------------

// File: rtl/store_fwd_buffer.sv
// Purpose: in-order store buffer between MEM and the data SRAM, with per-byte store-to-load forwarding.
// Latency: a pushed store is offered on mem_req the next cycle; forwarding is combinational from buffered state.
// Backpressure: st_ready drops when all DEPTH entries are held; the head waits on mem_req until mem_ack.
module store_fwd_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st_valid,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_wdata,
  input  logic [DATA_W/8-1:0] st_wstrb,
  output logic                st_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic [DATA_W-1:0]   ld_fwd_data,
  output logic [DATA_W/8-1:0] ld_fwd_mask,
  output logic                ld_fwd_full,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  output logic                empty
);

  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Lane-offset bits of a byte address; cleared so that entries hold word addresses.
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

  // Per-entry payload; the low lane-offset bits of addr_q are always zero.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [NB-1:0]     strb_q [DEPTH];

  logic [DEPTH-1:0]  vld_q,   vld_d;
  logic [PW-1:0]     head_q,  head_d;
  logic [PW-1:0]     tail_q,  tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] ld_line;
  logic [PW-1:0]     fwd_idx;

  // Ready comes only from registered occupancy so mem_ack never reaches st_ready.
  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign mem_req  = !empty;
  assign push     = st_valid && st_ready;
  assign pop      = mem_req && mem_ack;

  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign mem_wstrb = strb_q[head_q];

  assign ld_line = ld_addr & ~LANE_MASK;

  // Next-state for valid bits, pointers and occupancy; push and pop may coincide.
  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset drops every queued store, including the one on mem_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload write at the tail; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr & ~LANE_MASK;
      data_q[tail_q] <= st_wdata;
      strb_q[tail_q] <= st_wstrb;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest matching store wins each lane.
  always_comb begin
    ld_fwd_data = '0;
    ld_fwd_mask = '0;
    fwd_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (vld_q[fwd_idx] && (addr_q[fwd_idx] == ld_line)) begin
        ld_fwd_mask = ld_fwd_mask | strb_q[fwd_idx];
        for (int b = 0; b < NB; b++) begin
          if (strb_q[fwd_idx][b]) begin
            ld_fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
    ld_fwd_full = &ld_fwd_mask;
  end

endmodule
